// File: rtl/serial_cmd_master.sv
// UART-driven bus master: parses 'W' adr dat / 'R' adr command frames, runs one
// strobe/ack bus cycle per command and hands back a single response byte.
module serial_cmd_master #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    output logic       resp_valid_o,
    output logic [7:0] resp_data_o,
    input  logic       resp_ready_i,
    output logic       err_o
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TO_W      = 8;
    localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;
    localparam int unsigned HALF_LAST = (CLKS_PER_BIT / 2) - 1;
    localparam int unsigned TO_LAST   = ACK_TIMEOUT - 1;

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_TO  = 8'h15;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_OP, P_ADR, P_DAT, BUS, RESP} p_state_t;

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit_idx, rx_bit_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_done_c;

    p_state_t         p_state, p_state_n;
    logic             is_write, is_write_n;
    logic [TO_W-1:0]  bus_cnt, bus_cnt_n;
    logic             stb_n, we_n, resp_valid_n, err_n;
    logic [7:0]       adr_n, dat_n, resp_data_n;

    // Two-flop synchronizer plus a delayed copy for start-edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit_idx <= rx_bit_idx_n;
            rx_shift   <= rx_shift_n;
        end
    end

    // Receiver: half-bit start check, then mid-bit sampling of data and stop
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt + CNT_W'(1);
        rx_bit_idx_n = rx_bit_idx;
        rx_shift_n   = rx_shift;
        byte_done_c  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) rx_state_n = R_START;
            end
            R_START: begin
                if (rx_cnt == CNT_W'(HALF_LAST)) begin
                    rx_cnt_n     = '0;
                    rx_bit_idx_n = '0;
                    rx_state_n   = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == CNT_W'(BIT_LAST)) begin
                    rx_cnt_n     = '0;
                    rx_shift_n   = {rx_sync, rx_shift[7:1]};
                    rx_bit_idx_n = rx_bit_idx + 3'd1;
                    if (rx_bit_idx == 3'd7) rx_state_n = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt == CNT_W'(BIT_LAST)) begin
                    rx_cnt_n    = '0;
                    byte_done_c = 1'b1;
                    rx_state_n  = R_IDLE;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            p_state      <= P_OP;
            is_write     <= 1'b0;
            bus_cnt      <= '0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            p_state      <= p_state_n;
            is_write     <= is_write_n;
            bus_cnt      <= bus_cnt_n;
            stb_o        <= stb_n;
            we_o         <= we_n;
            adr_o        <= adr_n;
            dat_o        <= dat_n;
            resp_valid_o <= resp_valid_n;
            resp_data_o  <= resp_data_n;
            err_o        <= err_n;
        end
    end

    // Parser and bus/response sequencing; the stop bit is rx_sync at byte_done_c
    always_comb begin
        p_state_n    = p_state;
        is_write_n   = is_write;
        bus_cnt_n    = bus_cnt;
        stb_n        = stb_o;
        we_n         = we_o;
        adr_n        = adr_o;
        dat_n        = dat_o;
        resp_valid_n = resp_valid_o;
        resp_data_n  = resp_data_o;
        err_n        = 1'b0;
        case (p_state)
            P_OP: begin
                if (byte_done_c) begin
                    if (rx_sync && rx_shift == OP_WR) begin
                        is_write_n = 1'b1;
                        p_state_n  = P_ADR;
                    end else if (rx_sync && rx_shift == OP_RD) begin
                        is_write_n = 1'b0;
                        p_state_n  = P_ADR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            P_ADR: begin
                if (byte_done_c) begin
                    if (!rx_sync) begin
                        err_n     = 1'b1;
                        p_state_n = P_OP;
                    end else begin
                        adr_n = rx_shift;
                        if (is_write) begin
                            p_state_n = P_DAT;
                        end else begin
                            p_state_n = BUS;
                            stb_n     = 1'b1;
                            we_n      = 1'b0;
                            bus_cnt_n = '0;
                        end
                    end
                end
            end
            P_DAT: begin
                if (byte_done_c) begin
                    if (!rx_sync) begin
                        err_n     = 1'b1;
                        p_state_n = P_OP;
                    end else begin
                        dat_n     = rx_shift;
                        p_state_n = BUS;
                        stb_n     = 1'b1;
                        we_n      = 1'b1;
                        bus_cnt_n = '0;
                    end
                end
            end
            BUS: begin
                if (byte_done_c) err_n = 1'b1;
                if (ack_i) begin
                    stb_n        = 1'b0;
                    we_n         = 1'b0;
                    resp_data_n  = is_write ? RESP_ACK : dat_i;
                    resp_valid_n = 1'b1;
                    p_state_n    = RESP;
                end else if (bus_cnt == TO_W'(TO_LAST)) begin
                    stb_n        = 1'b0;
                    we_n         = 1'b0;
                    resp_data_n  = RESP_TO;
                    resp_valid_n = 1'b1;
                    err_n        = 1'b1;
                    p_state_n    = RESP;
                end else begin
                    bus_cnt_n = bus_cnt + TO_W'(1);
                end
            end
            RESP: begin
                if (byte_done_c) err_n = 1'b1;
                if (resp_ready_i) begin
                    resp_valid_n = 1'b0;
                    p_state_n    = P_OP;
                end
            end
            default: p_state_n = P_OP;
        endcase
    end

endmodule

// File: tb/tb_serial_cmd_master.sv
// Directed bench for serial_cmd_master: UART command frames in, scoreboarded
// bus cycles and response bytes out.
module tb_serial_cmd_master;

    localparam int unsigned CPB = 4;
    localparam int unsigned TO  = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       stb_o, we_o;
    logic [7:0] adr_o, dat_o;
    logic [7:0] dat_i = 8'h00;
    logic       ack_i = 1'b0;
    logic       resp_valid_o;
    logic [7:0] resp_data_o;
    logic       resp_ready_i = 1'b0;
    logic       err_o;

    int n_checks = 0;
    int n_err    = 0;
    int err_cnt  = 0;
    int stb_cyc  = 0;
    int err_base = 0;
    logic stb_prev = 1'b0;
    logic rv_prev  = 1'b0;
    logic [16:0] bus_e;
    logic [7:0]  resp_e;
    logic [16:0] exp_bus[$];
    logic [7:0]  exp_resp[$];

    serial_cmd_master #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i),
        .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .resp_ready_i(resp_ready_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        rx_i = 1'b1;
        repeat (CPB) tick();
        for (int i = 0; i < 10; i++) begin
            rx_i = frame[i];
            repeat (CPB) tick();
        end
        rx_i = 1'b1;
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (!stb_o && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(stb_o), 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!resp_valid_o && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(resp_valid_o), 32'd1);
    endtask

    task automatic release_resp(input string tag);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check(tag, 32'(resp_valid_o), 32'd0);
    endtask

    // Scoreboard monitors: each new strobe and each new response is popped and compared
    always @(negedge clk_i) begin
        if (err_o) err_cnt++;
        if (stb_o) stb_cyc++;
        if (stb_o && !stb_prev) begin
            check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
            if (exp_bus.size() != 0) begin
                bus_e = exp_bus.pop_front();
                check("bus_fields", 32'({we_o, adr_o, dat_o}), 32'(bus_e));
            end
        end
        if (resp_valid_o && !rv_prev) begin
            check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
            if (exp_resp.size() != 0) begin
                resp_e = exp_resp.pop_front();
                check("resp_data", 32'(resp_data_o), 32'(resp_e));
            end
        end
        stb_prev = stb_o;
        rv_prev  = resp_valid_o;
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_adr", 32'(adr_o), 32'h00);
        check("rst_dat", 32'(dat_o), 32'h00);
        check("rst_rv", 32'(resp_valid_o), 32'd0);
        check("rst_rd", 32'(resp_data_o), 32'h00);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        repeat (4) tick();

        // Write: ack after two cycles, response 0x06
        err_base = err_cnt;
        exp_bus.push_back({1'b1, 8'h32, 8'hA5});
        exp_resp.push_back(8'h06);
        stb_cyc = 0;
        send_byte(8'h57, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_stb("wr_stb");
        tick();
        check("wr_hold", 32'({stb_o, we_o, adr_o, dat_o}), 32'({1'b1, 1'b1, 8'h32, 8'hA5}));
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("wr_stb_drop", 32'(stb_o), 32'd0);
        check("wr_stb_cycles", 32'(stb_cyc), 32'd3);
        wait_resp("wr_resp");
        release_resp("wr_release");
        check("wr_err", 32'(err_cnt - err_base), 32'd0);

        // Read: data returned and held until ready
        exp_bus.push_back({1'b0, 8'h81, 8'hA5});
        exp_resp.push_back(8'h3C);
        send_byte(8'h52, 1'b1);
        send_byte(8'h81, 1'b1);
        wait_stb("rd_stb");
        tick();
        ack_i = 1'b1;
        dat_i = 8'h3C;
        tick();
        ack_i = 1'b0;
        dat_i = 8'h00;
        wait_resp("rd_resp");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rd_hold", 32'({resp_valid_o, resp_data_o}), 32'({1'b1, 8'h3C}));
        end
        release_resp("rd_release");

        // Timeout: no ack, strobe lasts exactly TO cycles, response 0x15
        err_base = err_cnt;
        stb_cyc = 0;
        exp_bus.push_back({1'b0, 8'h44, 8'hA5});
        exp_resp.push_back(8'h15);
        send_byte(8'h52, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_stb("to_stb");
        wait_resp("to_resp");
        check("to_stb_low", 32'(stb_o), 32'd0);
        release_resp("to_release");
        check("to_stb_cycles", 32'(stb_cyc), 32'(TO));
        check("to_err", 32'(err_cnt - err_base), 32'd1);

        // Bad opcode, then a framing error mid-command, then a clean write
        err_base = err_cnt;
        stb_cyc = 0;
        send_byte(8'h41, 1'b1);
        repeat (4) tick();
        check("op_err", 32'(err_cnt - err_base), 32'd1);
        send_byte(8'h57, 1'b1);
        send_byte(8'h32, 1'b0);
        repeat (4) tick();
        check("stop_err", 32'(err_cnt - err_base), 32'd2);
        check("err_no_bus", 32'(stb_cyc), 32'd0);
        exp_bus.push_back({1'b1, 8'h10, 8'h01});
        exp_resp.push_back(8'h06);
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_stb("rec_stb");
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        wait_resp("rec_resp");
        release_resp("rec_release");

        // One-cycle glitch with a stray ack while idle: nothing happens
        err_base = err_cnt;
        stb_cyc = 0;
        ack_i = 1'b1;
        rx_i = 1'b0;
        tick();
        rx_i = 1'b1;
        repeat (30) tick();
        ack_i = 1'b0;
        check("gl_err", 32'(err_cnt - err_base), 32'd0);
        check("gl_stb", 32'(stb_cyc), 32'd0);
        check("gl_rv", 32'(resp_valid_o), 32'd0);

        // Reset while the strobe is up: strobe drops at once, no response later
        exp_bus.push_back({1'b1, 8'h77, 8'h5A});
        send_byte(8'h57, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h5A, 1'b1);
        wait_stb("rb_stb");
        tick();
        rst_i = 1'b0;
        #1;
        check("rb_stb_async", 32'(stb_o), 32'd0);
        check("rb_adr_async", 32'(adr_o), 32'h00);
        repeat (3) tick();
        rst_i = 1'b1;
        ack_i = 1'b1;
        repeat (3) tick();
        ack_i = 1'b0;
        repeat (20) tick();
        check("rb_rv", 32'(resp_valid_o), 32'd0);
        check("rb_stb", 32'(stb_o), 32'd0);

        check("bus_q_empty", 32'(exp_bus.size()), 32'd0);
        check("resp_q_empty", 32'(exp_resp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_cmd_master.md
SERIAL_CMD_MASTER -- requirements
Module: serial_cmd_master

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_i cycles per UART bit (legal 4..65535).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning max clk_i cycles to wait for ack_i (legal 1..255).
REQ-003 SHALL have port clk_i, input, 1, meaning system clock; all state on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port rx_i, input, 1, meaning UART serial command input (LPC TXD1), idle high, 8N1.
REQ-006 SHALL have port stb_o, output, 1, meaning bus master strobe.
REQ-007 SHALL have port we_o, output, 1, meaning bus write enable.
REQ-008 SHALL have port adr_o, output, 8, meaning bus address; [7:4] is the slave base, [3:0] the register.
REQ-009 SHALL have port dat_o, output, 8, meaning bus write data.
REQ-010 SHALL have port dat_i, input, 8, meaning bus read data, valid with ack_i.
REQ-011 SHALL have port ack_i, input, 1, meaning slave acknowledge.
REQ-012 SHALL have port resp_valid_o, output, 1, meaning response byte available.
REQ-013 SHALL have port resp_data_o, output, 8, meaning response byte.
REQ-014 SHALL have port resp_ready_i, input, 1, meaning downstream serializer accepts the response.
REQ-015 SHALL have port err_o, output, 1, meaning one-cycle pulse on any dropped or invalid byte.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer before use; the second flop resets to 1.
REQ-017 SHALL start a receive on a synchronized 1->0 edge, then re-sample at CLKS_PER_BIT/2; high there aborts silently to idle.
REQ-018 SHALL sample 8 data bits LSB first at mid-bit, spaced CLKS_PER_BIT apart, then the stop bit.
REQ-019 SHALL deliver a byte only if stop bit = 1; stop = 0 drops the byte, pulses err_o, and returns the parser to P_OP.
REQ-020 SHALL run parser FSM states P_OP, P_ADR, P_DAT, BUS, RESP.
REQ-021 SHALL, in P_OP: byte 0x57 ('W') latches write and goes to P_ADR; 0x52 ('R') latches read and goes to P_ADR; any other byte pulses err_o and stays in P_OP.
REQ-022 SHALL, in P_ADR: latch the byte into adr_o; a write goes to P_DAT, a read goes to BUS.
REQ-023 SHALL, in P_DAT: latch the byte into dat_o and go to BUS.
REQ-024 SHALL, on entry to BUS: assert stb_o and drive we_o; hold stb_o, we_o, adr_o and dat_o stable until the cycle ends.
REQ-025 SHALL end the cycle in the clock where ack_i = 1 with stb_o = 1, so stb_o is low the following cycle; it shall capture dat_i in that same clock.
REQ-026 SHALL count cycles in BUS; if ACK_TIMEOUT cycles pass without ack_i, it shall drop stb_o, load response 0x15 and pulse err_o.
REQ-027 SHALL load the response: read = captured dat_i; write = 0x06; then enter RESP with resp_valid_o = 1.
REQ-028 SHALL hold resp_valid_o and resp_data_o stable until a clock with resp_ready_i = 1, then deassert resp_valid_o and return to P_OP.
REQ-029 SHALL drop any byte completed while in BUS or RESP and pulse err_o; the receiver itself keeps running.
REQ-030 SHALL ignore ack_i while stb_o = 0.
REQ-031 SHALL, if ack_i arrives in the same cycle the timeout expires, treat it as ack (normal response).
REQ-032 SHALL have at most one bus cycle outstanding; there is no pipelining.

Reset
REQ-033 SHALL, while rst_i = 0, immediately force: stb_o = 0, we_o = 0, adr_o = 0x00, dat_o = 0x00, resp_valid_o = 0, resp_data_o = 0x00, err_o = 0, FSM = P_OP, receiver idle, counters 0.
REQ-034 SHALL, on reset mid-operation (partial frame, BUS or RESP), discard that operation entirely; no response is emitted after reset release.

Verification (CLKS_PER_BIT = 4, ACK_TIMEOUT = 8)
REQ-035 SHALL cover write: frames 0x57, 0x32, 0xA5; slave acks after 2 cycles -> one stb_o cycle with we_o = 1, adr_o = 0x32, dat_o = 0xA5; then resp 0x06.
REQ-036 SHALL cover read: frames 0x52, 0x81; slave acks with dat_i = 0x3C -> stb_o with we_o = 0, adr_o = 0x81; resp 0x3C held until resp_ready_i = 1.
REQ-037 SHALL cover timeout: read with no ack_i -> stb_o high exactly 8 cycles, then low; resp 0x15; err_o pulses once.
REQ-038 SHALL cover framing/opcode errors: 0x41 opcode -> err_o, no bus cycle; a frame with stop = 0 mid-command -> err_o; next 0x57, 0x10, 0x01 completes normally.
REQ-039 SHALL cover a glitch: rx_i low for 1 cycle -> no byte delivered, no err_o.
REQ-040 SHALL cover reset during BUS: rst_i low while stb_o = 1 -> stb_o = 0 immediately; no resp_valid_o after release.
